// File: rtl/turn_sequencer.sv
// rtl/turn_sequencer.sv - per-frame turn controller: hero input/move, then each enemy read/commit
// Sole writer of the entity position file; all outputs registered from the next state.
module turn_sequencer #(
  parameter int NUM_ENEMIES = 4,
  parameter int INPUT_WAIT  = 1000,
  parameter int IDX_W       = 4
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             FRAME_TICK,
  input  logic [2:0]       USER_INPUT,
  output logic             GET_INPUT,
  input  logic [8:0]       HERO_NEW_X,
  input  logic [8:0]       HERO_NEW_Y,
  input  logic [8:0]       ENEMY_NEXT_X,
  input  logic [8:0]       ENEMY_NEXT_Y,
  input  logic             BLOCKED,
  output logic [IDX_W-1:0] ENT_SEL,
  output logic             ENT_WE,
  output logic [8:0]       ENT_WX,
  output logic [8:0]       ENT_WY,
  output logic             TURN_DONE,
  output logic [15:0]      TURN_COUNT,
  output logic             BUSY,
  output logic             OVERRUN
);

  localparam int CNT_W = $clog2(INPUT_WAIT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INPUT_WAIT - 1);
  localparam logic [IDX_W-1:0] LAST_K   = IDX_W'(NUM_ENEMIES);
  localparam logic [IDX_W-1:0] FIRST_K  = IDX_W'(1);

  typedef enum logic [2:0] {
    IDLE, WAIT_KEY, HERO_CHECK, HERO_WRITE, ENEMY_READ, ENEMY_CHECK, ENEMY_WRITE, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [8:0]       wx_q, wx_d, wy_q, wy_d;
  logic             get_input_q, ent_we_q, turn_done_q, busy_q, overrun_q;
  logic [IDX_W-1:0] ent_sel_q;
  logic [15:0]      turn_count_q;
  logic             key_valid;

  assign key_valid = (USER_INPUT >= 3'd1) && (USER_INPUT <= 3'd4);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    wx_d    = wx_q;
    wy_d    = wy_q;
    case (state_q)
      IDLE: begin
        if (FRAME_TICK) begin
          state_d = WAIT_KEY;
          cnt_d   = '0;
        end
      end
      WAIT_KEY: begin
        // A key arriving on the last timeout cycle still wins.
        if (key_valid) begin
          state_d = HERO_CHECK;
        end else if (cnt_q == LAST_CNT) begin
          state_d = ENEMY_READ;
          k_d     = FIRST_K;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HERO_CHECK: begin
        k_d = FIRST_K;
        if (!BLOCKED) begin
          state_d = HERO_WRITE;
          wx_d    = HERO_NEW_X;
          wy_d    = HERO_NEW_Y;
        end else begin
          state_d = ENEMY_READ;
        end
      end
      HERO_WRITE: begin
        state_d = ENEMY_READ;
        k_d     = FIRST_K;
      end
      ENEMY_READ: state_d = ENEMY_CHECK;
      ENEMY_CHECK: begin
        if (!BLOCKED) begin
          state_d = ENEMY_WRITE;
          wx_d    = ENEMY_NEXT_X;
          wy_d    = ENEMY_NEXT_Y;
        end else if (k_q == LAST_K) begin
          state_d = DONE;
        end else begin
          state_d = ENEMY_READ;
          k_d     = k_q + IDX_W'(1);
        end
      end
      ENEMY_WRITE: begin
        if (k_q == LAST_K) begin
          state_d = DONE;
        end else begin
          state_d = ENEMY_READ;
          k_d     = k_q + IDX_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      k_q          <= '0;
      wx_q         <= '0;
      wy_q         <= '0;
      get_input_q  <= 1'b0;
      ent_sel_q    <= '0;
      ent_we_q     <= 1'b0;
      turn_done_q  <= 1'b0;
      turn_count_q <= '0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      wx_q        <= wx_d;
      wy_q        <= wy_d;
      get_input_q <= (state_d == WAIT_KEY);
      ent_sel_q   <= (state_d == ENEMY_READ || state_d == ENEMY_CHECK ||
                      state_d == ENEMY_WRITE) ? k_d : '0;
      ent_we_q    <= (state_d == HERO_WRITE) || (state_d == ENEMY_WRITE);
      turn_done_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
      if (state_d == DONE) begin
        turn_count_q <= turn_count_q + 16'd1;
      end
      if (FRAME_TICK && state_q != IDLE) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign GET_INPUT  = get_input_q;
  assign ENT_SEL    = ent_sel_q;
  assign ENT_WE     = ent_we_q;
  assign ENT_WX     = wx_q;
  assign ENT_WY     = wy_q;
  assign TURN_DONE  = turn_done_q;
  assign TURN_COUNT = turn_count_q;
  assign BUSY       = busy_q;
  assign OVERRUN    = overrun_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// tb/tb_turn_sequencer.sv - scoreboard bench for turn_sequencer (NUM_ENEMIES=4, INPUT_WAIT=8)
module tb_turn_sequencer;

  logic        clk = 1'b0;
  logic        RESET_N = 1'b0;
  logic        FRAME_TICK = 1'b0;
  logic [2:0]  USER_INPUT = 3'd0;
  logic        GET_INPUT;
  logic [8:0]  hero_x = 9'd101;
  logic [8:0]  hero_y = 9'd50;
  logic [8:0]  ENEMY_NEXT_X, ENEMY_NEXT_Y;
  logic        BLOCKED;
  logic [3:0]  ENT_SEL;
  logic        ENT_WE;
  logic [8:0]  ENT_WX, ENT_WY;
  logic        TURN_DONE;
  logic [15:0] TURN_COUNT;
  logic        BUSY, OVERRUN;
  logic [15:0] block_mask = 16'd0;

  int checks = 0;
  int errors = 0;
  logic [21:0] wq[$];
  logic [15:0] dq[$];
  logic [15:0] exp_turns = 16'd0;

  always #5 clk = ~clk;

  // Enemy AI and collision checker models.
  assign ENEMY_NEXT_X = 9'(ENT_SEL * 10);
  assign ENEMY_NEXT_Y = 9'(ENT_SEL * 20);
  assign BLOCKED      = block_mask[ENT_SEL];

  turn_sequencer #(.NUM_ENEMIES(4), .INPUT_WAIT(8), .IDX_W(4)) dut (
    .CLOCK_50(clk), .RESET_N(RESET_N), .FRAME_TICK(FRAME_TICK), .USER_INPUT(USER_INPUT),
    .GET_INPUT(GET_INPUT), .HERO_NEW_X(hero_x), .HERO_NEW_Y(hero_y),
    .ENEMY_NEXT_X(ENEMY_NEXT_X), .ENEMY_NEXT_Y(ENEMY_NEXT_Y), .BLOCKED(BLOCKED),
    .ENT_SEL(ENT_SEL), .ENT_WE(ENT_WE), .ENT_WX(ENT_WX), .ENT_WY(ENT_WY),
    .TURN_DONE(TURN_DONE), .TURN_COUNT(TURN_COUNT), .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe and turn-done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (RESET_N) begin
      if (ENT_WE) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got sel=%0d x=%0d y=%0d expected none", ENT_SEL, ENT_WX, ENT_WY);
        end else begin
          chk("write_sel_x_y", {10'd0, ENT_SEL, ENT_WX, ENT_WY}, {10'd0, wq.pop_front()});
        end
      end
      if (TURN_DONE) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_turn_done: got count=%0d expected none", TURN_COUNT);
        end else begin
          chk("turn_count_at_done", {16'd0, TURN_COUNT}, {16'd0, dq.pop_front()});
        end
      end
    end
  end

  task automatic push_writes(input logic [2:0] key, input logic [4:0] mask);
    if (key >= 3'd1 && key <= 3'd4 && !mask[0]) wq.push_back({4'd0, hero_x, hero_y});
    for (int k = 1; k <= 4; k++)
      if (!mask[k]) wq.push_back({4'(k), 9'(10 * k), 9'(20 * k)});
  endtask

  task automatic run_turn(input string name, input logic [2:0] key, input logic [4:0] mask,
                          input int exp_gi, input int exp_lat, input int ovr_at);
    int lat = 0;
    int gi = 0;
    bit done = 0;
    @(negedge clk);
    push_writes(key, mask);
    exp_turns = exp_turns + 16'd1;
    dq.push_back(exp_turns);
    USER_INPUT = key;
    block_mask = {11'd0, mask};
    FRAME_TICK = 1'b1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (GET_INPUT) gi++;
      if (TURN_DONE) done = 1;
      FRAME_TICK = (lat == ovr_at);
    end
    FRAME_TICK = 1'b0;
    USER_INPUT = 3'd0;
    chk({name, "_done_seen"}, {31'd0, done}, 32'd1);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_get_input_cycles"}, gi, exp_gi);
    @(negedge clk);
    chk({name, "_writes_left"}, wq.size(), 0);
    chk({name, "_busy_after"}, {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    int lat;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {GET_INPUT, ENT_SEL, ENT_WE, ENT_WX, ENT_WY, TURN_DONE, TURN_COUNT, BUSY, OVERRUN}, 32'd0);
    RESET_N = 1'b1;
    repeat (2) @(negedge clk);

    run_turn("normal", 3'd4, 5'b00000, 1, 16, -1);
    chk("count_after_normal", {16'd0, TURN_COUNT}, 32'd1);

    // Reset while enemy 1 is being written.
    @(negedge clk);
    wq.push_back({4'd0, hero_x, hero_y});
    wq.push_back({4'd1, 9'd10, 9'd20});
    USER_INPUT = 3'd2;
    FRAME_TICK = 1'b1;
    lat = 0;
    while (lat < 6) begin
      @(negedge clk);
      lat++;
      FRAME_TICK = 1'b0;
    end
    chk("pre_reset_we", {31'd0, ENT_WE}, 32'd1);
    #1 RESET_N = 1'b0;
    #1 chk("midturn_reset_outputs", {GET_INPUT, ENT_SEL, ENT_WE, ENT_WX, ENT_WY, TURN_DONE, TURN_COUNT, BUSY, OVERRUN}, 32'd0);
    chk("midturn_reset_writes_left", wq.size(), 0);
    USER_INPUT = 3'd0;
    repeat (2) @(negedge clk);
    RESET_N = 1'b1;
    exp_turns = 16'd0;
    repeat (20) @(negedge clk);
    chk("post_reset_idle", {TURN_COUNT, 15'd0, BUSY}, 32'd0);

    run_turn("clean_after_reset", 3'd4, 5'b00000, 1, 16, -1);
    chk("count_after_reset_turn", {16'd0, TURN_COUNT}, 32'd1);

    run_turn("timeout", 3'd0, 5'b00000, 8, 21, -1);
    run_turn("blocked", 3'd1, 5'b00101, 1, 14, -1);

    chk("overrun_clear", {31'd0, OVERRUN}, 32'd0);
    run_turn("overrun", 3'd3, 5'b00000, 1, 16, 4);
    chk("overrun_set", {31'd0, OVERRUN}, 32'd1);
    repeat (5) @(negedge clk);
    chk("overrun_sticky_idle", {30'd0, OVERRUN, BUSY}, 32'd2);
    chk("count_after_overrun", {16'd0, TURN_COUNT}, 32'd4);

    @(negedge clk);
    force dut.turn_count_q = 16'hFFFF;
    #1 release dut.turn_count_q;
    exp_turns = 16'hFFFF;
    @(negedge clk);
    chk("preload_count", {16'd0, TURN_COUNT}, 32'h0000FFFF);
    run_turn("wrap_key6", 3'd6, 5'b00000, 8, 21, -1);
    chk("count_wrapped", {16'd0, TURN_COUNT}, 32'd0);

    chk("done_queue_empty", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
Per-frame game-turn controller that sequences the user-control datapath and shares the entity position file between the hero and NUM_ENEMIES enemies. On each FRAME_TICK it asserts GET_INPUT and waits for a keypress. It then commits the hero move, and finally steps every enemy through read/commit in index order. It is the single writer of the entity file and sits between the system core, the keypress/motion path, the collision checker and the enemy AI.

Parameters:
NUM_ENEMIES, 4, enemy count; entity indices 1..NUM_ENEMIES (0 = hero); legal range 1..15
INPUT_WAIT, 1000, max cycles spent in WAIT_KEY before the hero forfeits its move; must be ≥1
IDX_W, 4, width of ENT_SEL; must hold NUM_ENEMIES

Ports:
CLOCK_50  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
FRAME_TICK  in  1  one-cycle pulse; starts a turn
USER_INPUT  in  3  decoded key: 0 none, 1 up, 2 down, 3 left, 4 right, 5-7 treated as none
GET_INPUT  out  1  capture enable to keypress routine
HERO_NEW_X, HERO_NEW_Y  in  9 each  proposed hero position from motion block
ENEMY_NEXT_X, ENEMY_NEXT_Y  in  9 each  proposed position for entity ENT_SEL from enemy AI
BLOCKED  in  1  collision checker verdict for the proposal currently presented; combinational
ENT_SEL  out  IDX_W  entity index addressed in the position file
ENT_WE  out  1  write strobe to position file
ENT_WX, ENT_WY  out  9 each  write data
TURN_DONE  out  1  one-cycle pulse at end of turn
TURN_COUNT  out  16  completed turns; wraps 0xFFFF→0
BUSY  out  1  high in every state except IDLE
OVERRUN  out  1  sticky; set when FRAME_TICK arrives while BUSY

Behaviour:
- Reset (async, RESET_N=0): state IDLE; GET_INPUT=0, ENT_SEL=0, ENT_WE=0, ENT_WX/WY=0, TURN_DONE=0, TURN_COUNT=0, BUSY=0, OVERRUN=0; wait counter and enemy index cleared. A reset mid-turn aborts the turn; no further writes occur.
- All outputs are registered; ENT_WE is high for exactly one cycle per committed write.
- IDLE: ENT_SEL=0. FRAME_TICK=1 → WAIT_KEY, wait counter=0.
- WAIT_KEY: GET_INPUT=1, ENT_SEL=0. If USER_INPUT ∈ {1..4} → HERO_CHECK. Otherwise, when the counter reaches INPUT_WAIT-1 → ENEMY_READ with k=1 and the hero does not move. Otherwise increment the counter. A valid key on the final timeout cycle takes priority: go to HERO_CHECK.
- HERO_CHECK (1 cycle): GET_INPUT=0, ENT_SEL=0, HERO_NEW is stable. BLOCKED=0 → HERO_WRITE. BLOCKED=1 → ENEMY_READ, k=1, no write.
- HERO_WRITE (1 cycle): ENT_WE=1, ENT_WX/WY = HERO_NEW_X/Y as sampled in HERO_CHECK. Next state ENEMY_READ, k=1.
- ENEMY_READ (1 cycle): ENT_SEL=k; the position file and AI settle. Next state ENEMY_CHECK.
- ENEMY_CHECK (1 cycle): ENT_SEL=k. BLOCKED=0 → ENEMY_WRITE, with ENEMY_NEXT latched. BLOCKED=1 → skip the write. In either case, if k=NUM_ENEMIES → DONE after the optional write; else k+1 and go to ENEMY_READ after the optional write.
- ENEMY_WRITE (1 cycle): ENT_WE=1, ENT_SEL=k, latched data. Next state per the k rule above.
- DONE (1 cycle): TURN_DONE=1, TURN_COUNT+1 (wraps), ENT_SEL=0. Next state IDLE.
- Latency: key valid on the first WAIT_KEY cycle with no blocks gives hero write on cycle 3 after FRAME_TICK and TURN_DONE on cycle 3+3·NUM_ENEMIES+1.
- FRAME_TICK while BUSY (including DONE) is ignored for sequencing and sets OVERRUN. FRAME_TICK coincident with reset is ignored.
- 9-bit position values pass through unmodified; this block performs no arithmetic on them. Bounds and wall legality are decided solely by BLOCKED.

Test Plan:
- Reset mid-ENEMY_WRITE: assert RESET_N=0 → all outputs 0 immediately; no ENT_WE afterwards; next FRAME_TICK starts a clean turn with TURN_COUNT=0.
- NUM_ENEMIES=4, key 4 (right) on first WAIT_KEY cycle, BLOCKED=0, HERO_NEW=(101,50), ENEMY_NEXT=(10k,20k) → writes (0:101,50), (1:10,20)…(4:40,80) in order; TURN_DONE 16 cycles after FRAME_TICK; TURN_COUNT=1.
- INPUT_WAIT=8, USER_INPUT held 0 → GET_INPUT high exactly 8 cycles; no write to index 0; enemies 1..4 still written.
- Key 1, BLOCKED=1 in HERO_CHECK and for enemy 2 only → no index-0 write, no index-2 write; writes to 1, 3, 4 present; TURN_DONE still pulses.
- FRAME_TICK pulsed during ENEMY_READ → OVERRUN=1 and stays 1; current turn completes normally; no second turn starts until the next FRAME_TICK in IDLE.
- Preload TURN_COUNT to 0xFFFF via 65535 turns (or force) → next TURN_DONE gives TURN_COUNT=0; USER_INPUT=6 is treated as none and times out.
